// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - access size encodings carried on mem_size
//   - bit positions inside the two-bit WB control field
//   - MEM stage FSM state encoding
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // The reserved encoding 11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'b11) ? SZ_WORD : sz;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data formatter: picks the addressed byte/half lane out of a
// 32-bit bus word and sign- or zero-extends it. Purely combinational.
//   rdata      in  32  raw word returned by the data memory
//   off        in  2   byte offset of the access (addr[1:0])
//   size       in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   uns        in  1   zero-extend when 1, sign-extend when 0
//   data       out 32  formatted load value
module mem_load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        if (size == SZ_BYTE) begin
            data = uns ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        end else if (size == SZ_HALF) begin
            data = uns ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage. Issues data-memory loads/stores on a req/ack bus,
// stalls upstream while an access is outstanding and feeds the MEM/WB
// register (bubbles, wb_out=00, while waiting).
// Bus handshake: dmem_req is registered and held high, with addr/we/be/
// wdata stable, until the single-cycle dmem_ack strobe is seen or the
// ack timeout expires; acks outside the REQ state are ignored.
// Ports:
//   clock, reset_n                 clock, async active-low reset
//   ex_valid, mem_read, mem_write  EX/MEM op qualifiers
//   mem_size, load_unsigned        access size and load extension
//   alu_out, store_data            address / ALU result, store value
//   wb_in, reg_rd                  WB control and destination register
//   wb_out, mem_out, alu_pass,
//   reg_rd_out                     MEM/WB register inputs
//   stall                          freeze upstream stages
//   dmem_*                         data-memory bus
//   misalign_exc, bus_err          single-cycle exception pulses
//   state_dbg                      current FSM state
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int ADDR_W      = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ex_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              load_unsigned,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       store_data,
    input  logic [1:0]        wb_in,
    input  logic [4:0]        reg_rd,
    output logic [1:0]        wb_out,
    output logic [31:0]       mem_out,
    output logic [31:0]       alu_pass,
    output logic [4:0]        reg_rd_out,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              misalign_exc,
    output logic              bus_err,
    output logic [1:0]        state_dbg
);

    // Last counter value of the wait window; reaching it without an ack
    // is the timeout. Counter starts at 0 on the first REQ cycle.
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    mem_state_t  state_q, state_d;
    logic [31:0] alu_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic [1:0]  wb_q, size_q;
    logic [4:0]  rd_q;
    logic [7:0]  cnt_q;
    logic        we_q, uns_q, req_q, bus_err_q;

    logic        is_mem, is_store, misaligned, launch, timeout;
    logic [1:0]  eff_size;
    logic [3:0]  be_new;
    logic [31:0] wdata_new, load_data;

    assign is_mem     = mem_read | mem_write;
    assign is_store   = mem_write & ~mem_read;   // read wins when both set
    assign eff_size   = norm_size(mem_size);
    assign misaligned = ((eff_size == SZ_HALF) && alu_out[0]) ||
                        ((eff_size == SZ_WORD) && (alu_out[1:0] != 2'b00));
    assign launch     = (state_q == IDLE) && ex_valid && is_mem && !misaligned;
    assign timeout    = (state_q == REQ) && !dmem_ack && (cnt_q == TO_LAST);

    // Store lane placement; loads always enable the whole word.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = store_data;
        if (is_store && eff_size == SZ_BYTE) begin
            be_new    = 4'b0001 << alu_out[1:0];
            wdata_new = {4{store_data[7:0]}};
        end else if (is_store && eff_size == SZ_HALF) begin
            be_new    = 4'b0011 << alu_out[1:0];
            wdata_new = {2{store_data[15:0]}};
        end
    end

    mem_load_align u_align (
        .rdata (rdata_q),
        .off   (alu_q[1:0]),
        .size  (size_q),
        .uns   (uns_q),
        .data  (load_data)
    );

    always_comb begin
        state_d      = state_q;
        wb_out       = 2'b00;
        mem_out      = 32'h0;
        alu_pass     = alu_out;
        reg_rd_out   = reg_rd;
        stall        = 1'b0;
        misalign_exc = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid && !is_mem) begin
                    wb_out = wb_in;
                end else if (ex_valid && is_mem) begin
                    if (misaligned) begin
                        misalign_exc = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (dmem_ack || timeout) state_d = DONE;
            end
            DONE: begin
                // Upstream still presents the same op here; going straight
                // back to IDLE (not REQ) keeps it from being relaunched.
                wb_out     = wb_q;
                mem_out    = we_q ? 32'h0 : load_data;
                alu_pass   = alu_q;
                reg_rd_out = rd_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            alu_q     <= 32'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            be_q      <= 4'h0;
            wb_q      <= 2'b00;
            size_q    <= 2'b00;
            rd_q      <= 5'd0;
            cnt_q     <= 8'd0;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            req_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= 1'b0;
            if (launch) begin
                alu_q   <= alu_out;
                wdata_q <= wdata_new;
                be_q    <= be_new;
                we_q    <= is_store;
                wb_q    <= wb_in;
                rd_q    <= reg_rd;
                size_q  <= eff_size;
                uns_q   <= load_unsigned;
                cnt_q   <= 8'd0;
                req_q   <= 1'b1;
            end
            if (state_q == REQ) begin
                cnt_q <= cnt_q + 8'd1;
                if (dmem_ack) begin
                    rdata_q <= dmem_rdata;
                    req_q   <= 1'b0;
                end else if (timeout) begin
                    rdata_q   <= 32'h0;
                    req_q     <= 1'b0;
                    bus_err_q <= 1'b1;
                end
            end
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = req_q & we_q;
    assign dmem_be    = req_q ? be_q : 4'h0;
    assign dmem_addr  = {alu_q[ADDR_W-1:2], 2'b00};
    assign dmem_wdata = wdata_q;
    assign bus_err    = bus_err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import mips_mem_pkg::*;

  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        load_unsigned = 1'b0;
  logic [31:0] alu_out = 32'h0, store_data = 32'h0;
  logic [1:0]  wb_in = 2'b00;
  logic [4:0]  reg_rd = 5'd0;
  logic [1:0]  wb_out;
  logic [31:0] mem_out, alu_pass;
  logic [4:0]  reg_rd_out;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_ack = 1'b0;
  logic        misalign_exc, bus_err;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [38:0] exp_q[$];   // {wb, mem_out, rd}

  mem_access_stage #(.ACK_TIMEOUT(TO), .ADDR_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .load_unsigned(load_unsigned),
    .alu_out(alu_out), .store_data(store_data), .wb_in(wb_in), .reg_rd(reg_rd),
    .wb_out(wb_out), .mem_out(mem_out), .alu_pass(alu_pass), .reg_rd_out(reg_rd_out),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .misalign_exc(misalign_exc), .bus_err(bus_err),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [1:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] sh;
    if (sz == 2'b00) begin
      sh = rd >> (8 * off);
      return uns ? (sh & 32'h0000_00FF) : {{24{sh[7]}}, sh[7:0]};
    end
    if (sz == 2'b01) begin
      sh = off[1] ? (rd >> 16) : rd;
      return uns ? (sh & 32'h0000_FFFF) : {{16{sh[15]}}, sh[15:0]};
    end
    return rd;
  endfunction

  function automatic logic [3:0] exp_be(input logic st, input logic [1:0] sz, input logic [1:0] off);
    if (st && sz == 2'b00) return 4'b0001 << off;
    if (st && sz == 2'b01) return 4'b0011 << off;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] sd);
    if (sz == 2'b00) return {4{sd[7:0]}};
    if (sz == 2'b01) return {2{sd[15:0]}};
    return sd;
  endfunction

  task automatic idle_inputs();
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // driver: one memory access, ack in REQ cycle ack_at (0 = never ack)
  task automatic mem_op(input logic rd_en, input logic wr_en, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rdata, input logic [1:0] wb, input logic [4:0] rdst,
                        input int ack_at, input string nm);
    logic        st;
    logic [31:0] eout;
    logic [38:0] e;
    int          n, stall_n, exp_stall;
    logic        done;
    st   = wr_en & ~rd_en;
    eout = (st || ack_at == 0) ? 32'h0 : exp_load(rdata, addr[1:0], (sz == 2'b11) ? 2'b10 : sz, uns);
    exp_q.push_back({wb, eout, rdst});
    exp_stall = 1 + ((ack_at == 0) ? TO : ack_at);

    @(negedge clock);
    ex_valid = 1'b1; mem_read = rd_en; mem_write = wr_en; mem_size = sz;
    load_unsigned = uns; alu_out = addr; store_data = sd; wb_in = wb; reg_rd = rdst;
    #1;
    check_eq({nm, "_idle_wb"}, wb_out, 2'b00);
    check_eq({nm, "_idle_req"}, dmem_req, 1'b0);
    stall_n = stall ? 1 : 0;
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clock);
      dmem_ack = 1'b0;
      if (state_dbg == DONE) begin
        done = 1'b1;
      end else begin
        n++;
        if (stall) stall_n++;
        check_eq({nm, "_req"}, dmem_req, 1'b1);
        check_eq({nm, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        check_eq({nm, "_be"}, dmem_be, exp_be(st, sz, addr[1:0]));
        check_eq({nm, "_we"}, dmem_we, st);
        if (st) check_eq({nm, "_wdata"}, dmem_wdata, exp_wdata(sz, sd));
        if (n == ack_at) begin
          dmem_ack = 1'b1; dmem_rdata = rdata;
        end else begin
          dmem_rdata = $urandom;
        end
      end
    end
    check_eq({nm, "_reached_done"}, done, 1'b1);
    check_eq({nm, "_stall_cycles"}, stall_n, exp_stall);
    check_eq({nm, "_done_stall"}, stall, 1'b0);
    check_eq({nm, "_done_req"}, dmem_req, 1'b0);
    check_eq({nm, "_bus_err"}, bus_err, (ack_at == 0) ? 1'b1 : 1'b0);
    check_eq({nm, "_misalign"}, misalign_exc, 1'b0);
    // scoreboard pop at the DUT's output cycle
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({nm, "_wb_out"}, wb_out, e[38:37]);
      check_eq({nm, "_mem_out"}, mem_out, e[36:5]);
      check_eq({nm, "_rd_out"}, reg_rd_out, e[4:0]);
      check_eq({nm, "_alu_pass"}, alu_pass, addr);
    end
    // op still held through the DONE edge: must not relaunch
    @(negedge clock);
    check_eq({nm, "_no_relaunch_st"}, state_dbg, IDLE);
    check_eq({nm, "_no_relaunch_req"}, dmem_req, 1'b0);
    check_eq({nm, "_no_err_repeat"}, bus_err, 1'b0);
    idle_inputs();
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    logic        w;
    // reset state
    #1;
    check_eq("rst_req", dmem_req, 1'b0);
    check_eq("rst_we", dmem_we, 1'b0);
    check_eq("rst_be", dmem_be, 4'h0);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_misalign", misalign_exc, 1'b0);
    check_eq("rst_bus_err", bus_err, 1'b0);
    check_eq("rst_state", state_dbg, IDLE);
    #11 reset_n = 1'b1;

    // non-memory passthrough
    @(negedge clock);
    ex_valid = 1'b1; alu_out = 32'h0000_1234; wb_in = 2'b10; reg_rd = 5'd5;
    #1;
    check_eq("alu_wb", wb_out, 2'b10);
    check_eq("alu_pass", alu_pass, 32'h0000_1234);
    check_eq("alu_rd", reg_rd_out, 5'd5);
    check_eq("alu_stall", stall, 1'b0);
    check_eq("alu_mem_out", mem_out, 32'h0);
    @(negedge clock);
    check_eq("alu_no_req", dmem_req, 1'b0);
    ex_valid = 1'b0;
    #1;
    check_eq("bubble_wb", wb_out, 2'b00);

    // directed memory ops
    mem_op(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2'b11, 5'd8, 1, "lw_fast");
    mem_op(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h8012_3456, 2'b11, 5'd9, 1, "lb_s");
    mem_op(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h8012_3456, 2'b11, 5'd9, 2, "lbu");
    mem_op(1, 0, 2'b01, 0, 32'h102, 32'h0, 32'h9ABC_1234, 2'b11, 5'd3, 1, "lh_s");
    mem_op(1, 0, 2'b01, 1, 32'h100, 32'h0, 32'h1234_F00D, 2'b11, 5'd4, 3, "lhu");
    mem_op(0, 1, 2'b01, 0, 32'h202, 32'h0000_ABCD, 32'h0, 2'b00, 5'd0, 4, "sh_wait");
    mem_op(0, 1, 2'b00, 0, 32'h301, 32'h1122_33A5, 32'h0, 2'b00, 5'd0, 1, "sb");
    mem_op(0, 1, 2'b11, 0, 32'h304, 32'hCAFE_0001, 32'h0, 2'b00, 5'd0, 2, "sz11_store");
    mem_op(1, 1, 2'b10, 0, 32'h308, 32'h5555_5555, 32'h0BAD_F00D, 2'b11, 5'd7, 1, "rw_as_load");
    mem_op(1, 0, 2'b10, 0, 32'h400, 32'h0, 32'hFFFF_FFFF, 2'b11, 5'd10, 0, "lw_timeout");
    mem_op(1, 0, 2'b10, 0, 32'h404, 32'h0, 32'h7777_0001, 2'b11, 5'd11, TO, "ack_at_limit");

    // misaligned accesses
    @(negedge clock);
    ex_valid = 1'b1; mem_read = 1'b1; mem_size = 2'b10; alu_out = 32'h101; wb_in = 2'b11;
    #1;
    check_eq("mis_w_exc", misalign_exc, 1'b1);
    check_eq("mis_w_stall", stall, 1'b0);
    check_eq("mis_w_wb", wb_out, 2'b00);
    check_eq("mis_w_buserr", bus_err, 1'b0);
    @(negedge clock);
    check_eq("mis_w_no_req", dmem_req, 1'b0);
    mem_read = 1'b0; mem_write = 1'b1; mem_size = 2'b01; alu_out = 32'h203;
    #1;
    check_eq("mis_h_exc", misalign_exc, 1'b1);
    @(negedge clock);
    check_eq("mis_h_no_req", dmem_req, 1'b0);
    idle_inputs();
    #1;
    check_eq("mis_clear", misalign_exc, 1'b0);

    // random aligned traffic
    for (int k = 0; k < 8; k++) begin
      sz = 2'($urandom_range(0, 2));
      a  = {$urandom_range(0, 4095), 2'b00};
      if (sz == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
      if (sz == 2'b01) a[1]   = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      mem_op(~w, w, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
             2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom_range(1, 4), "rnd");
    end

    // reset during REQ, late ack ignored
    @(negedge clock);
    ex_valid = 1'b1; mem_read = 1'b1; mem_size = 2'b10; alu_out = 32'h500; wb_in = 2'b11;
    @(negedge clock);
    check_eq("rst_mid_req_up", dmem_req, 1'b1);
    #2;
    reset_n = 1'b0;
    idle_inputs();
    #1;
    check_eq("rst_mid_req", dmem_req, 1'b0);
    check_eq("rst_mid_stall", stall, 1'b0);
    check_eq("rst_mid_state", state_dbg, IDLE);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    @(negedge clock);
    dmem_ack = 1'b0;
    check_eq("late_ack_state", state_dbg, IDLE);
    check_eq("late_ack_req", dmem_req, 1'b0);
    check_eq("late_ack_wb", wb_out, 2'b00);
    check_eq("late_ack_mem_out", mem_out, 32'h0);
    check_eq("late_ack_stall", stall, 1'b0);
    check_eq("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
